ap_unsi_div_8b4b: RTL and testbench



---
 rtl/ap_unsi_div_8b4b_pkg.sv | 40 ++++
 rtl/ap_unsi_div_8b4b_div_step.sv | 26 ++
 rtl/ap_unsi_div_8b4b.sv | 150 +++++++++++++++
 tb/tb_ap_unsi_div_8b4b.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_unsi_div_8b4b_pkg.sv
// Shared types and sizing helpers for the unsigned restoring divider
// (ap_unsi_div_8b4b). The optional approximate mode is selected by the
// AP_DIV_TRUNC_EN macro; the helpers below take that choice as an argument.
package ap_div_pkg;

    // Controller states of the iterative divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Default divisor/remainder width; dividend and quotient are twice this.
    localparam int DW_DEF    = 4;
    // Default number of low quotient bits skipped in approximate mode.
    localparam int TRUNC_DEF = 2;

    // Number of restoring steps for one division.
    function automatic int f_nstep(input int dw, input int trunc, input bit trunc_en);
        int n;
        if (trunc_en) begin
            n = 2 * dw - trunc;
        end else begin
            n = 2 * dw;
        end
        return n;
    endfunction

    // Width of the step counter, which counts NSTEP-1 down to 0.
    function automatic int f_cnt_w(input int nstep);
        int w;
        if (nstep <= 1) begin
            w = 1;
        end else begin
            w = $clog2(nstep);
        end
        return w;
    endfunction

endpackage

// File: rtl/ap_unsi_div_8b4b_div_step.sv
// One combinational restoring-division step: shift the partial remainder
// left by the next dividend bit, trial-subtract the divisor and keep the
// difference when it does not borrow. The quotient bit reports that choice.
module div_step #(
    parameter int DW = 4
) (
    input  logic [DW:0]   i_prem,
    input  logic          i_bit,
    input  logic [DW-1:0] i_dvs,
    output logic [DW:0]   o_prem,
    output logic          o_qbit
);

    logic [DW+1:0] w_shift;
    logic [DW:0]   w_diff;
    logic          w_ge;

    // The partial remainder is always below the divisor, so after the
    // shift it needs DW+1 bits; the extra top bit keeps the compare honest.
    assign w_shift = {i_prem, i_bit};
    assign w_ge    = (w_shift >= {2'b00, i_dvs});
    assign w_diff  = w_shift[DW:0] - {1'b0, i_dvs};
    assign o_prem  = w_ge ? w_diff : w_shift[DW:0];
    assign o_qbit  = w_ge;

endmodule

// File: rtl/ap_unsi_div_8b4b.sv
// Sequential unsigned radix-2 restoring divider: 2*DW-bit dividend by a
// DW-bit divisor, one quotient bit per clock, valid/ready on both sides and
// a single operation in flight. Defining AP_DIV_TRUNC_EN selects the
// approximate mode that skips the low TRUNC quotient bits and drives rem=0.
module ap_unsi_div_8b4b
    import ap_div_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int TRUNC = TRUNC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [2*DW-1:0] dvd,
    input  logic [DW-1:0]   dvs,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [2*DW-1:0] quo,
    output logic [DW-1:0]   rem,
    output logic            dz
);

`ifdef AP_DIV_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif
    localparam int NSTEP = f_nstep(DW, TRUNC, TRUNC_EN);
    localparam int CW    = f_cnt_w(NSTEP);

    state_e          r_state;
    logic            r_in_rdy;
    logic            r_out_vld;
    logic [2*DW-1:0] r_quo;
    logic [DW-1:0]   r_rem;
    logic            r_dz;
    logic [CW-1:0]   r_cnt;
    logic [2*DW-1:0] r_dvd;
    logic [DW-1:0]   r_dvs;
    logic [DW:0]     r_prem;
    logic [2*DW-1:0] r_qacc;

    logic [DW:0]     w_prem_next;
    logic            w_qbit;
    logic [2*DW-1:0] w_qacc_next;
    logic [2*DW-1:0] w_quo_fin;
    logic [DW-1:0]   w_rem_fin;

    // Single iterative step, fed by the dividend MSB of the shift register.
    div_step #(
        .DW (DW)
    ) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[2*DW-1]),
        .i_dvs  (r_dvs),
        .o_prem (w_prem_next),
        .o_qbit (w_qbit)
    );

    assign w_qacc_next = {r_qacc[2*DW-2:0], w_qbit};

`ifdef AP_DIV_TRUNC_EN
    // Only the top NSTEP quotient bits were produced; realign them and
    // leave the skipped low bits at zero. The remainder is meaningless here.
    assign w_quo_fin = w_qacc_next << TRUNC;
    assign w_rem_fin = {DW{1'b0}};
`else
    assign w_quo_fin = w_qacc_next;
    assign w_rem_fin = w_prem_next[DW-1:0];
`endif

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_in_rdy  <= 1'b0;
            r_out_vld <= 1'b0;
            r_quo     <= {(2*DW){1'b0}};
            r_rem     <= {DW{1'b0}};
            r_dz      <= 1'b0;
            r_cnt     <= {CW{1'b0}};
            r_dvd     <= {(2*DW){1'b0}};
            r_dvs     <= {DW{1'b0}};
            r_prem    <= {(DW+1){1'b0}};
            r_qacc    <= {(2*DW){1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_in_rdy && in_vld) begin
                        r_dvd    <= dvd;
                        r_dvs    <= dvs;
                        r_in_rdy <= 1'b0;
                        if (dvs == {DW{1'b0}}) begin
                            // Divide by zero finishes at the accepting edge.
                            r_state   <= DONE;
                            r_out_vld <= 1'b1;
                            r_quo     <= {(2*DW){1'b1}};
                            r_rem     <= dvd[DW-1:0];
                            r_dz      <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_cnt   <= CW'(NSTEP - 1);
                            r_prem  <= {(DW+1){1'b0}};
                            r_qacc  <= {(2*DW){1'b0}};
                        end
                    end else begin
                        // Covers the first cycle after reset release.
                        r_in_rdy <= 1'b1;
                    end
                end
                CALC: begin
                    r_dvd  <= {r_dvd[2*DW-2:0], 1'b0};
                    r_prem <= w_prem_next;
                    r_qacc <= w_qacc_next;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state   <= DONE;
                        r_out_vld <= 1'b1;
                        r_quo     <= w_quo_fin;
                        r_rem     <= w_rem_fin;
                        r_dz      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        r_state   <= IDLE;
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                    end else begin
                        r_out_vld <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_in_rdy  <= 1'b0;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign in_rdy  = r_in_rdy;
    assign out_vld = r_out_vld;
    assign quo     = r_quo;
    assign rem     = r_rem;
    assign dz      = r_dz;

endmodule

// File: tb/tb_ap_unsi_div_8b4b.sv
// Directed self-checking bench for ap_unsi_div_8b4b (exact mode by default;
// expectations switch when AP_DIV_TRUNC_EN is defined).
module tb_ap_unsi_div_8b4b;

`ifdef AP_DIV_TRUNC_EN
    localparam int E_LAT = 7;
    localparam logic [7:0] E_Q200_7 = 8'd28;  localparam logic [3:0] E_R200_7 = 4'd0;
    localparam logic [7:0] E_Q255_1 = 8'd252; localparam logic [3:0] E_R255_1 = 4'd0;
    localparam logic [7:0] E_Q15_15 = 8'd0;   localparam logic [3:0] E_R15_15 = 4'd0;
    localparam logic [7:0] E_Q9_3   = 8'd0;   localparam logic [3:0] E_R9_3   = 4'd0;
    localparam logic [7:0] E_Q50_5  = 8'd8;   localparam logic [3:0] E_R50_5  = 4'd0;
    localparam logic [7:0] E_Q203_7 = 8'd28;
`else
    localparam int E_LAT = 9;
    localparam logic [7:0] E_Q200_7 = 8'd28;  localparam logic [3:0] E_R200_7 = 4'd4;
    localparam logic [7:0] E_Q255_1 = 8'd255; localparam logic [3:0] E_R255_1 = 4'd0;
    localparam logic [7:0] E_Q15_15 = 8'd1;   localparam logic [3:0] E_R15_15 = 4'd0;
    localparam logic [7:0] E_Q9_3   = 8'd3;   localparam logic [3:0] E_R9_3   = 4'd0;
    localparam logic [7:0] E_Q50_5  = 8'd10;  localparam logic [3:0] E_R50_5  = 4'd0;
    localparam logic [7:0] E_Q203_7 = 8'd29;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] quo;
    logic [3:0] rem;
    logic       dz;

    int n_err = 0;
    int n_chk = 0;

    ap_unsi_div_8b4b dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .dvd     (dvd),
        .dvs     (dvs),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .quo     (quo),
        .rem     (rem),
        .dz      (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from a negedge and return at the negedge where
    // out_vld is first seen; lat counts edges with the accepting edge as 1.
    task automatic issue(input logic [7:0] a, input logic [3:0] b, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (in_rdy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL issue_in_rdy: got %b want 1", in_rdy);
            return;
        end
        in_vld = 1'b1;
        dvd    = a;
        dvs    = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_vld = 1'b0;
        dvd    = ~a;
        dvs    = ~b;
        while (out_vld !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_chk++;
        if (out_vld !== 1'b1) begin
            n_err++;
            $display("FAIL issue_out_vld timeout: got %b want 1", out_vld);
        end
    endtask

    // Accept the pending result; returns at the following negedge.
    task automatic pop();
        out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; dvd = 8'd0; dvs = 4'd0;
        #1;
        n_chk++;
        if ({in_rdy, out_vld, quo, rem, dz} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_vals: got rdy=%b vld=%b quo=%0d rem=%0d dz=%b want all 0",
                     in_rdy, out_vld, quo, rem, dz);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_rdy_after: got %b want 1", in_rdy);
        end
    endtask

    task automatic test_basic();
        int lat;
        out_rdy = 1'b1;
        issue(8'd200, 4'd7, lat);
        n_chk++;
        if (lat !== E_LAT) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want %0d", lat, E_LAT);
        end
        n_chk++;
        if (quo !== E_Q200_7 || rem !== E_R200_7 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL basic_200_7: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                     quo, rem, dz, E_Q200_7, E_R200_7);
        end
        pop();
        n_chk++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after_pop: got rdy=%b vld=%b want rdy=1 vld=0", in_rdy, out_vld);
        end
    endtask

    task automatic test_sweep();
        int lat;
        int bad;
        logic [7:0] eq;
        logic [3:0] er;
        issue(8'd255, 4'd1, lat);
        n_chk++;
        if (quo !== E_Q255_1 || rem !== E_R255_1 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_255_1: got q=%0d r=%0d dz=%b want q=%0d r=%0d", quo, rem, dz, E_Q255_1, E_R255_1);
        end
        pop();
        issue(8'd15, 4'd15, lat);
        n_chk++;
        if (quo !== E_Q15_15 || rem !== E_R15_15 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_15_15: got q=%0d r=%0d dz=%b want q=%0d r=%0d", quo, rem, dz, E_Q15_15, E_R15_15);
        end
        pop();
        issue(8'd0, 4'd5, lat);
        n_chk++;
        if (quo !== 8'd0 || rem !== 4'd0 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_0_5: got q=%0d r=%0d dz=%b want q=0 r=0", quo, rem, dz);
        end
        pop();
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
`ifdef AP_DIV_TRUNC_EN
                eq = 8'(((a / b) >> 2) << 2);
                er = 4'd0;
`else
                eq = 8'(a / b);
                er = 4'(a % b);
`endif
                issue(8'(a), 4'(b), lat);
                n_chk++;
                if (quo !== eq || rem !== er || dz !== 1'b0) begin
                    n_err++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL exhaustive %0d/%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d",
                                 a, b, quo, rem, dz, eq, er);
                end
                pop();
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(8'd100, 4'd0, lat);
        n_chk++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL dz_latency: got %0d want 1", lat);
        end
        n_chk++;
        if (quo !== 8'd255 || rem !== 4'd4 || dz !== 1'b1) begin
            n_err++;
            $display("FAIL dz_100_0: got q=%0d r=%0d dz=%b want q=255 r=4 dz=1", quo, rem, dz);
        end
        pop();
        issue(8'd9, 4'd3, lat);
        n_chk++;
        if (quo !== E_Q9_3 || rem !== E_R9_3 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL dz_next_9_3: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0", quo, rem, dz, E_Q9_3, E_R9_3);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_rdy = 1'b0;
        issue(8'd50, 4'd5, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1;
            dvd    = 8'd7;
            dvs    = 4'd1;
            @(posedge clk);
            @(negedge clk);
            if (out_vld !== 1'b1 || in_rdy !== 1'b0 || quo !== E_Q50_5 || rem !== E_R50_5 || dz !== 1'b0)
                bad++;
        end
        in_vld = 1'b0;
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold: got %0d bad cycles (q=%0d r=%0d vld=%b rdy=%b) want 0",
                     bad, quo, rem, out_vld, in_rdy);
        end
        pop();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_vld !== 1'b0 || in_rdy !== 1'b1) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_no_ghost_op: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid_calc();
        int bad;
        in_vld = 1'b1;
        dvd    = 8'd200;
        dvs    = 4'd7;
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in_rdy, out_vld, quo, rem, dz} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_mid_calc: got rdy=%b vld=%b quo=%0d rem=%0d dz=%b want all 0",
                     in_rdy, out_vld, quo, rem, dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_calc_rdy: got %b want 1", in_rdy);
        end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_vld !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_mid_calc_stale_vld: got %0d cycles with out_vld want 0", bad);
        end
    endtask

    task automatic test_trunc();
        int lat;
        issue(8'd203, 4'd7, lat);
        n_chk++;
        if (quo !== E_Q203_7 || rem !== 4'd0 || lat !== E_LAT) begin
            n_err++;
            $display("FAIL trunc_203_7: got q=%0d r=%0d lat=%0d want q=%0d r=0 lat=%0d",
                     quo, rem, lat, E_Q203_7, E_LAT);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_trunc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
